// File: rtl/wb_cpu_port_arbiter.sv
// wb_cpu_port_arbiter: N-channel pipelined Wishbone B4 round-robin arbiter.
// Optional slave watchdog is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_cpu_port_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_w,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel,
  input  logic [NUM_MASTERS-1:0]      m_cyc,
  input  logic [NUM_MASTERS-1:0]      m_stb,
  input  logic [NUM_MASTERS-1:0]      m_we,
  output logic [NUM_MASTERS-1:0]      m_stall,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [NUM_MASTERS-1:0]      m_err,
  output logic [DW-1:0]               m_dat_r,
  output logic [AW-1:0]               s_adr,
  output logic [DW-1:0]               s_dat_w,
  output logic [DW/8-1:0]             s_sel,
  output logic                        s_cyc,
  output logic                        s_stb,
  output logic                        s_we,
  input  logic                        s_stall,
  input  logic                        s_ack,
  input  logic                        s_err,
  input  logic [DW-1:0]               s_dat_r,
  output logic [NUM_MASTERS-1:0]      grant
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, GRANTED} state_e;

  state_e                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [PW-1:0]          rr_q;
  logic [PW-1:0]          pick;
  logic [CW-1:0]          out_q;
  logic [CW-1:0]          out_d;
  logic                   found;
  logic                   own;
  logic                   cap;
  logic                   tmo;
  logic                   issue;
  logic                   resp;
  logic                   rel;

  assign own     = (state_q == GRANTED);
  assign cap     = (out_q == MAXO);
  assign grant   = grant_q;
  assign m_dat_r = s_dat_r;

  // Round-robin scan starting just after the last owner.
  always_comb begin
    int idx;
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && m_cyc[PW'(idx)]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    s_adr   = m_adr[int'(rr_q)*AW +: AW];
    s_dat_w = m_dat_w[int'(rr_q)*DW +: DW];
    s_sel   = m_sel[int'(rr_q)*(DW/8) +: DW/8];
    s_we    = m_we[rr_q];
    s_cyc   = own & m_cyc[rr_q] & ~tmo;
    s_stb   = own & m_stb[rr_q] & ~cap & ~tmo;
    issue   = s_stb & ~s_stall;
    resp    = own & (s_ack | s_err);
    m_stall = '1;
    m_ack   = '0;
    m_err   = '0;
    if (own) begin
      m_stall[rr_q] = s_stall | cap;
      m_ack[rr_q]   = s_ack;
      m_err[rr_q]   = s_err | tmo;
    end
    rel   = own & (~m_cyc[rr_q] | tmo);
    out_d = out_q;
    if (issue && !resp) begin
      out_d = out_q + 1'b1;
    end else if (!issue && resp && out_q != '0) begin
      out_d = out_q - 1'b1;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_q;

  // Fires on the Nth consecutive stalled cycle, counting the current one.
  assign tmo = own & (out_q != '0) & ~(s_ack | s_err) & (wd_q == TLIM);

  always_ff @(posedge clk) begin
    if (rst || !own || out_q == '0 || s_ack || s_err || tmo) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= PW'(NUM_MASTERS - 1);
      out_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= GRANTED;
            grant_q <= NUM_MASTERS'(1) << pick;
            rr_q    <= pick;
          end
        end
        GRANTED: begin
          if (rel) begin
            state_q <= IDLE;
            grant_q <= '0;
            out_q   <= '0;
          end else begin
            out_q <= out_d;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cpu_port_arbiter.sv
// Self-checking bench for wb_cpu_port_arbiter: behavioural model plus
// directed literal scenarios and randomized traffic.
module tb_wb_cpu_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N-1:0]    m_stall, m_ack, m_err;
  logic [DW-1:0]   m_dat_r;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [SW-1:0]   s_sel;
  logic            s_cyc, s_stb, s_we;
  logic            s_stall, s_ack, s_err;
  logic [DW-1:0]   s_dat_r;
  logic [N-1:0]    grant;

  always #5 clk = ~clk;

  wb_cpu_port_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW),
    .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err),
    .m_dat_r(m_dat_r),
    .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err),
    .s_dat_r(s_dat_r), .grant(grant)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: owner (-1 = nobody), last winner, in-flight count, stall run.
  int   own = -1;
  int   rr  = N - 1;
  int   outst = 0;
  int   wd  = 0;
  int   e_own;
  logic e_issue;
  logic check_en = 1'b0;
  int   acc;

  int         left [2];
  int         ph [2];
  logic       ackn;
  logic [1:0] seq [$];
  logic [1:0] lastg;
  int         zrun;
  logic [1:0] exp2 [4];
  int         hit;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] egr, est, eak, eer;
    logic ecyc, estb, capv, rsp, tmo;
    int g, ob;
    #1;
    ob   = outst;
    capv = (outst == MO);
    rsp  = s_ack | s_err;
    tmo  = 1'b0;
    egr  = '0; est = '1; eak = '0; eer = '0;
    ecyc = 1'b0; estb = 1'b0;
    g    = own;
    if (own >= 0) begin
`ifdef WB_ARB_TIMEOUT_EN
      tmo = (outst > 0) && !rsp && (wd == TO - 1);
`endif
      egr[g] = 1'b1;
      ecyc   = m_cyc[g] && !tmo;
      estb   = m_stb[g] && !capv && !tmo;
      est[g] = s_stall || capv;
      eak[g] = s_ack;
      eer[g] = s_err || tmo;
    end
    if (check_en) begin
      chk("grant", grant, egr);
      chk("s_cyc", s_cyc, ecyc);
      chk("s_stb", s_stb, estb);
      chk("m_stall", m_stall, est);
      chk("m_ack", m_ack, eak);
      chk("m_err", m_err, eer);
      chk("m_dat_r", m_dat_r, s_dat_r);
      if (ecyc) begin
        chk("s_adr", s_adr, m_adr[g*AW +: AW]);
        chk("s_dat_w", s_dat_w, m_dat_w[g*DW +: DW]);
        chk("s_sel", s_sel, m_sel[g*SW +: SW]);
        chk("s_we", s_we, m_we[g]);
      end
    end
    if (s_stb && !s_stall) acc++;
    e_own   = own;
    e_issue = estb && !s_stall;
    if (rst) begin
      own = -1; rr = N - 1; outst = 0; wd = 0;
    end else if (own < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (rr + k) % N;
        if (m_cyc[c]) begin
          own = c; rr = c;
          break;
        end
      end
    end else if (!m_cyc[own] || tmo) begin
      own = -1; outst = 0; wd = 0;
    end else begin
      if (e_issue && !rsp) outst++;
      else if (!e_issue && rsp && outst > 0) outst--;
      wd = (ob > 0 && !rsp) ? wd + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    m_cyc = '0; m_stb = '0; m_we = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    m_adr = '0; m_dat_w = '0; m_sel = '0; s_dat_r = '0;
    idle_in();
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_scyc", s_cyc, 1'b0);
    chk("rst_stall", m_stall, 2'b11);
    rst = 1'b0;

    // Single read: 1-cycle grant latency, ack forwarded.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    m_adr[0 +: AW] = 32'h0000_1000;
    #1 chk("t1_lat_scyc", s_cyc, 1'b0);
    step();
    #1 chk("t1_scyc", s_cyc, 1'b1);
    chk("t1_adr", s_adr, 32'h0000_1000);
    chk("t1_stall1", m_stall[1], 1'b1);
    step();
    m_stb[0] = 1'b0; s_ack = 1'b1;
    #1 chk("t1_ack", m_ack[0], 1'b1);
    chk("t1_stall1b", m_stall[1], 1'b1);
    step();
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    step(); step();

    // Two masters alternating single reads.
    do_reset();
    left = '{2, 2}; ph = '{0, 0}; ackn = 1'b0; lastg = '0; zrun = 0;
    exp2 = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int cy = 0; cy < 60 && (left[0] + left[1]) > 0; cy++) begin
      for (int i = 0; i < 2; i++) begin
        m_cyc[i] = left[i] > 0 && ph[i] != 2;
        m_stb[i] = m_cyc[i] && ph[i] == 0;
      end
      s_ack = ackn;
      #1;
      if (grant != 0) begin
        if (grant != lastg) begin
          seq.push_back(grant);
          if (lastg != 0) chk("t2_dead", zrun, 1);
          lastg = grant;
        end
        zrun = 0;
      end else begin
        zrun++;
      end
      step();
      for (int i = 0; i < 2; i++) if (ph[i] == 2) ph[i] = 0;
      if (e_own >= 0) begin
        if (ph[e_own] == 0 && e_issue) ph[e_own] = 1;
        else if (ph[e_own] == 1 && s_ack) begin
          ph[e_own] = 2;
          left[e_own]--;
        end
      end
      ackn = e_issue;
    end
    chk("t2_count", seq.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < seq.size()) chk("t2_order", seq[k], exp2[k]);
    idle_in();
    step(); step();

    // Outstanding cap with a silent slave.
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; acc = 0;
    repeat (10) step();
    chk("t3_cap", acc, 4);
    #1 chk("t3_stall", m_stall[0], 1'b1);
    s_ack = 1'b1; step();
    s_ack = 1'b0; acc = 0;
    repeat (4) step();
    chk("t3_one_more", acc, 1);

    // Same-cycle issue+ack, then spurious ack at zero.
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; acc = 0;
    step(); step(); step();
    s_ack = 1'b1; step();
    s_ack = 1'b0; acc = 0;
    repeat (6) step();
    chk("t4_same", acc, 2);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; step();
    m_cyc[0] = 1'b1; step();
    s_ack = 1'b1; step(); step();
    s_ack = 1'b0; m_stb[0] = 1'b1; acc = 0;
    repeat (8) step();
    chk("t4_no_underflow", acc, 4);

    // Reset in the middle of a burst owned by master 1.
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    #1 chk("t5_grant1", grant, 2'b10);
    step(); step(); step();
    m_stb[1] = 1'b0; m_cyc[0] = 1'b1;
    rst = 1'b1; step(); rst = 1'b0;
    #1 chk("t5_grant0", grant, 2'b00);
    chk("t5_scyc", s_cyc, 1'b0);
    step();
    #1 chk("t5_m0_wins", grant, 2'b01);
    idle_in(); step(); step();

    // Hung slave.
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step(); step();
    m_stb[0] = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    hit = -1;
    for (int k = 1; k <= 40 && hit < 0; k++) begin
      #1;
      if (m_err[0]) begin
        hit = k;
        chk("t6_scyc", s_cyc, 1'b0);
      end
      step();
    end
    chk("t6_tmo_at", hit, 16);
    #1 chk("t6_idle", grant, 2'b00);
`else
    repeat (120) step();
    #1 chk("t6_held", grant, 2'b01);
`endif
    idle_in(); step(); step();

    // Randomized traffic against the model.
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = m_cyc[i] & 1'($urandom_range(0, 1));
        m_we[i]  = 1'($urandom_range(0, 1));
        m_adr[i*AW +: AW]   = $urandom;
        m_dat_w[i*DW +: DW] = $urandom;
        m_sel[i*SW +: SW]   = SW'($urandom);
      end
      s_stall = ($urandom_range(0, 3) == 0);
      s_ack   = ($urandom_range(0, 2) == 0);
      s_err   = ($urandom_range(0, 19) == 0);
      s_dat_r = $urandom;
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
